// File: rtl/amstrad_ga_regs.sv
// Gate Array / Plus ASIC I/O register front-end: snoops Z80 I/O writes, holds the
// RAM-config, MRER, RMR2, ROM-select and pen/palette state, and runs the Plus unlock detector.
module amstrad_ga_regs #(
  parameter int SEQ_LEN = 17
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        io_WR,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        plus_mode,
  input  logic        ram64k,
  output logic [7:0]  ram_config,
  output logic [7:0]  mrer,
  output logic [7:0]  rom_select,
  output logic [4:0]  rmr2,
  output logic [4:0]  pen,
  output logic        pal_we,
  output logic [4:0]  pal_idx,
  output logic [4:0]  pal_data,
  output logic        asic_unlocked
);

  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  logic             old_wr;
  logic [IDX_W-1:0] idx;
  logic             wr_evt;
  logic             ga_hit;
  logic             ram_hit;
  logic             rom_hit;
  logic             crtc_hit;
  logic             unused_addr_bits;

  // Byte the ASIC expects at each position of the unlock sequence.
  function automatic logic [7:0] seq_byte(input logic [IDX_W-1:0] i);
    case (i)
      5'd0:    seq_byte = 8'hFF;
      5'd1:    seq_byte = 8'h00;
      5'd2:    seq_byte = 8'hFF;
      5'd3:    seq_byte = 8'h77;
      5'd4:    seq_byte = 8'hB3;
      5'd5:    seq_byte = 8'h51;
      5'd6:    seq_byte = 8'hA8;
      5'd7:    seq_byte = 8'hD4;
      5'd8:    seq_byte = 8'h62;
      5'd9:    seq_byte = 8'h39;
      5'd10:   seq_byte = 8'h9C;
      5'd11:   seq_byte = 8'h46;
      5'd12:   seq_byte = 8'h2B;
      5'd13:   seq_byte = 8'h15;
      5'd14:   seq_byte = 8'h8A;
      5'd15:   seq_byte = 8'hCD;
      default: seq_byte = 8'hEE;
    endcase
  endfunction

  assign wr_evt   = ~old_wr & io_WR;
  assign ga_hit   = (A[15:14] == 2'b01);
  assign ram_hit  = ~A[15] & (D[7:6] == 2'b11) & ~ram64k;
  assign rom_hit  = ~A[13];
  assign crtc_hit = ~A[14] & (A[9:8] == 2'b00);

  // Partial address decode: the remaining address bits are don't-care.
  assign unused_addr_bits = ^{A[12:10], A[7:0]};

  always_ff @(posedge CLK) begin
    // NOTE: reset wins over a coincident write event, so a write landing in reset is dropped.
    if (reset) begin
      old_wr        <= 1'b0;
      ram_config    <= '0;
      mrer          <= '0;
      rom_select    <= '0;
      rmr2          <= '0;
      pen           <= '0;
      pal_we        <= 1'b0;
      pal_idx       <= '0;
      pal_data      <= '0;
      asic_unlocked <= 1'b0;
      idx           <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every decode below sees pre-edge pen/asic_unlocked.
      old_wr <= io_WR;
      pal_we <= 1'b0;

      if (wr_evt) begin
        if (ga_hit) begin
          case (D[7:6])
            2'b00: pen <= D[4] ? 5'h10 : {1'b0, D[3:0]};
            2'b01: begin
              pal_we   <= 1'b1;
              pal_idx  <= pen;
              pal_data <= D[4:0];
            end
            2'b10: begin
              if (asic_unlocked && D[5]) rmr2 <= D[4:0];
              else                       mrer <= D;
            end
            default: ;
          endcase
        end
        if (ram_hit) ram_config <= D;
        if (rom_hit) rom_select <= D;
      end

      // A mismatching 0xFF may itself be the start of a fresh sequence.
      if (!plus_mode) begin
        idx           <= '0;
        asic_unlocked <= 1'b0;
      end else if (wr_evt && crtc_hit) begin
        if (idx == LAST_IDX) begin
          asic_unlocked <= (D == seq_byte(LAST_IDX));
          idx           <= '0;
        end else if (D == seq_byte(idx)) begin
          idx <= idx + 1'b1;
        end else begin
          idx <= (D == 8'hFF) ? IDX_W'(1) : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_amstrad_ga_regs.sv
// Scoreboard bench for amstrad_ga_regs: stimulus pushes hand-computed register state per
// write; a monitor detects each io_WR rising edge itself and compares one cycle later.
module tb_amstrad_ga_regs;

  typedef struct packed {
    logic [7:0] ram_config;
    logic [7:0] mrer;
    logic [7:0] rom_select;
    logic [4:0] rmr2;
    logic [4:0] pen;
    logic       pal_we;
    logic [4:0] pal_idx;
    logic [4:0] pal_data;
    logic       unlocked;
    logic [4:0] idx;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        io_WR = 1'b0;
  logic [15:0] A = '0;
  logic [7:0]  D = '0;
  logic        plus_mode = 1'b0;
  logic        ram64k = 1'b0;
  logic [7:0]  ram_config, mrer, rom_select;
  logic [4:0]  rmr2, pen, pal_idx, pal_data;
  logic        pal_we, asic_unlocked;

  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses   = 0;
  bit   mon_en   = 1'b0;
  exp_t q[$];
  exp_t e;

  localparam logic [7:0] SEQ [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8,
    8'hD4, 8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};

  amstrad_ga_regs #(.SEQ_LEN(17)) dut (
    .CLK(CLK), .reset(reset), .io_WR(io_WR), .A(A), .D(D),
    .plus_mode(plus_mode), .ram64k(ram64k),
    .ram_config(ram_config), .mrer(mrer), .rom_select(rom_select), .rmr2(rmr2),
    .pen(pen), .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
    .asic_unlocked(asic_unlocked)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One Z80 I/O write; io_WR stays high for 'hold' cycles, then one low cycle.
  task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit pw = 1'b0,
                    input int hold = 1);
    @(negedge CLK);
    A = a;
    D = d;
    io_WR = 1'b1;
    e.pal_we = pw;
    q.push_back(e);
    e.pal_we = 1'b0;
    repeat (hold) @(negedge CLK);
    io_WR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (q.size() != 0) check("scoreboard_drain", q.size(), 0);
  endtask

  // Monitor: its own edge detector on io_WR decides when the DUT owes a response.
  initial begin
    bit   prev = 1'b0;
    bit   evt;
    exp_t x;
    forever begin
      @(posedge CLK);
      evt  = io_WR && !prev && !reset;
      prev = reset ? 1'b0 : io_WR;
      #1;
      if (pal_we === 1'b1) pulses++;
      if (mon_en) begin
        if (evt) begin
          if (q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_underflow: write seen with no expectation queued");
          end else begin
            x = q.pop_front();
            check("ram_config", ram_config, x.ram_config);
            check("mrer", mrer, x.mrer);
            check("rom_select", rom_select, x.rom_select);
            check("rmr2", rmr2, x.rmr2);
            check("pen", pen, x.pen);
            check("pal_we", pal_we, x.pal_we);
            check("pal_idx", pal_idx, x.pal_idx);
            check("pal_data", pal_data, x.pal_data);
            check("asic_unlocked", asic_unlocked, x.unlocked);
            check("unlock_idx", dut.idx, x.idx);
          end
        end else begin
          check("pal_we_idle", pal_we, 0);
        end
      end
    end
  end

  initial begin
    e = '0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    #1;
    check("rst_ram_config", ram_config, 0);
    check("rst_mrer", mrer, 0);
    check("rst_rom_select", rom_select, 0);
    check("rst_pen", pen, 0);
    check("rst_pal_we", pal_we, 0);
    check("rst_unlocked", asic_unlocked, 0);
    mon_en = 1'b1;

    // RAM config, then the same kind of write ignored under ram64k.
    e.ram_config = 8'hC5; wr(16'h7F00, 8'hC5);
    ram64k = 1'b1;        wr(16'h7F00, 8'hEA);
    ram64k = 1'b0;

    e.rom_select = 8'h07; wr(16'hDF00, 8'h07);

    // Pen select, palette strobe, border pen.
    e.pen = 5'h03; wr(16'h7F00, 8'h03);
    e.pal_idx = 5'h03; e.pal_data = 5'h14; wr(16'h7F00, 8'h54, 1'b1);
    e.pen = 5'h10; wr(16'h7F00, 8'h10);

    // Unlock sequence with a non-CRTC write wedged in after the first byte.
    plus_mode = 1'b1;
    e.idx = 5'd1; wr(16'hBC00, 8'hFF);
    e.mrer = 8'h8C; e.rom_select = 8'h8C; wr(16'h5C00, 8'h8C);
    for (int i = 1; i < 16; i++) begin
      e.idx = 5'(i + 1);
      wr(16'hBC00, SEQ[i]);
    end
    e.idx = 5'd0; e.unlocked = 1'b1; wr(16'hBC00, 8'hEE);
    e.rmr2 = 5'h03; wr(16'h7F00, 8'hA3);

    // Wrong final byte relocks; MRER writes then go back to mrer.
    for (int i = 0; i < 16; i++) begin
      e.idx = 5'(i + 1);
      wr(16'hBC00, SEQ[i]);
    end
    e.idx = 5'd0; e.unlocked = 1'b0; wr(16'hBC00, 8'h00);
    e.mrer = 8'hA3; wr(16'h7F00, 8'hA3);

    // Broken sequences, including a mismatching FF restarting at 1.
    e.idx = 5'd1; wr(16'hBC00, 8'hFF);
    e.idx = 5'd2; wr(16'hBC00, 8'h00);
    e.idx = 5'd3; wr(16'hBC00, 8'hFF);
    e.idx = 5'd0; wr(16'hBC00, 8'h12);
    e.idx = 5'd1; wr(16'hBC00, 8'hFF);
    e.idx = 5'd1; wr(16'hBC00, 8'hFF);
    e.idx = 5'd0; wr(16'hBC00, 8'h12);

    // Reset after eight bytes discards progress.
    for (int i = 0; i < 8; i++) begin
      e.idx = 5'(i + 1);
      wr(16'hBC00, SEQ[i]);
    end
    drain();
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    e = '0;
    #1;
    check("midrst_idx", dut.idx, 0);
    check("midrst_ram_config", ram_config, 0);
    for (int i = 8; i < 17; i++) wr(16'hBC00, SEQ[i]);

    // io_WR held high for ten cycles gives exactly one palette write.
    e.pen = 5'h05; wr(16'h7F00, 8'h05);
    e.pal_idx = 5'h05; e.pal_data = 5'h00; wr(16'h7F00, 8'h40, 1'b1, 10);

    drain();
    repeat (2) @(negedge CLK);
    check("pal_we_pulses", pulses, 2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
